// File: rtl/ucsbece152a_tl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ucsbece152a_tl_pkg
//  Description : Shared types and constants for the tail-light scheduler:
//                the animation mode encoding, the last phase of each
//                sequence, and the request arbitration rule.
//  Revision    : 1.0 - initial release
// ============================================================================
package ucsbece152a_tl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2,
        HAZARD = 2'd3
    } mode_t;

    // Last phase of a turn sweep and of a hazard flash
    localparam logic [1:0] TURN_LAST = 2'd3;
    localparam logic [1:0] HAZ_LAST  = 2'd1;

    // Hazard wins, and asking for both sides at once also means hazard
    function automatic mode_t arbitrate(input logic left, input logic right,
                                        input logic hazard);
        mode_t m;
        if (hazard || (left && right)) m = HAZARD;
        else if (left)                 m = LEFT;
        else if (right)                m = RIGHT;
        else                           m = IDLE;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ucsbece152a_tl_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : ucsbece152a_tl_pwm
//  Description : Running-light dimmer. Free-running period counter, duty
//                register reloaded only at period wrap, registered enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module ucsbece152a_tl_pwm #(
    parameter int PWM_PERIOD = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [$clog2(PWM_PERIOD):0]   duty_i,
    output logic                          dim_o
);

    localparam int CW = $clog2(PWM_PERIOD);
    localparam logic [CW-1:0] c_CNT_LAST = CW'(PWM_PERIOD - 1);

    logic [CW-1:0] r_cnt;
    logic [CW:0]   r_duty;
    logic          r_dim;
    logic          w_wrap;
    logic [CW-1:0] w_cnt_next;
    logic [CW:0]   w_duty_next;

    assign w_wrap      = (r_cnt == c_CNT_LAST);
    assign w_cnt_next  = w_wrap ? '0 : r_cnt + CW'(1);
    assign w_duty_next = w_wrap ? duty_i : r_duty;

    // Counter, duty and enable advance together; the enable is computed from
    // the next-cycle count/duty so it is valid in the same cycle they are
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_duty <= '0;
            r_dim  <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_duty <= w_duty_next;
            r_dim  <= ({1'b0, w_cnt_next} < w_duty_next);
        end
    end

    assign dim_o = r_dim;

endmodule
`default_nettype wire

// File: rtl/ucsbece152a_tl_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : ucsbece152a_tl_scheduler
//  Description : Tail-light animation scheduler. Divides the clock into
//                animation steps, arbitrates registered driver requests and
//                sequences turn sweeps / hazard flashes, plus a brake pipe
//                and a PWM dimmer for the running lights.
//  Revision    : 1.0 - initial release
// ============================================================================
module ucsbece152a_tl_scheduler
    import ucsbece152a_tl_pkg::*;
#(
    parameter int STEP_DIV   = 4,
    parameter int PWM_PERIOD = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          left_i,
    input  logic                          right_i,
    input  logic                          hazard_i,
    input  logic                          brake_i,
    input  logic [$clog2(PWM_PERIOD):0]   duty_i,
    output logic                          step_o,
    output mode_t                         mode_o,
    output logic [1:0]                    phase_o,
    output logic                          brake_o,
    output logic                          dim_o
);

    localparam int SW = $clog2(STEP_DIV);
    localparam logic [SW-1:0] c_STEP_LAST = SW'(STEP_DIV - 1);

    logic [SW-1:0] r_step_cnt;
    logic          w_step;
    logic          r_left_q;
    logic          r_right_q;
    logic          r_hazard_q;
    logic          r_brake_q;
    mode_t         w_arb;
    mode_t         r_mode;
    mode_t         w_mode_next;
    logic [1:0]    r_phase;
    logic [1:0]    w_phase_next;
    logic          w_boundary;

    assign w_step = (r_step_cnt == c_STEP_LAST);

    // Step divider: wraps after STEP_DIV cycles, pulse on the last count
    always_ff @(posedge clk) begin
        if (rst)         r_step_cnt <= '0;
        else if (w_step) r_step_cnt <= '0;
        else             r_step_cnt <= r_step_cnt + SW'(1);
    end

    // Single register stage on every driver request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_left_q   <= 1'b0;
            r_right_q  <= 1'b0;
            r_hazard_q <= 1'b0;
            r_brake_q  <= 1'b0;
        end else begin
            r_left_q   <= left_i;
            r_right_q  <= right_i;
            r_hazard_q <= hazard_i;
            r_brake_q  <= brake_i;
        end
    end

    assign w_arb = arbitrate(r_left_q, r_right_q, r_hazard_q);

    // A sequence may only be replaced once it has shown its last phase
    always_comb begin
        w_boundary = 1'b0;
        case (r_mode)
            IDLE:        w_boundary = 1'b1;
            LEFT, RIGHT: w_boundary = (r_phase == TURN_LAST);
            HAZARD:      w_boundary = (r_phase == HAZ_LAST);
            default:     w_boundary = 1'b1;
        endcase
    end

    // Mode/phase state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode  <= IDLE;
            r_phase <= 2'd0;
        end else begin
            r_mode  <= w_mode_next;
            r_phase <= w_phase_next;
        end
    end

    // Next mode/phase: hold between steps; a hazard request cuts a turn
    // sweep short, while a side change lets the current sweep finish
    always_comb begin
        w_mode_next  = r_mode;
        w_phase_next = r_phase;
        if (w_step) begin
            if (w_boundary) begin
                w_mode_next  = w_arb;
                w_phase_next = 2'd0;
            end else if ((r_mode != HAZARD) && (w_arb == HAZARD)) begin
                w_mode_next  = HAZARD;
                w_phase_next = 2'd0;
            end else begin
                w_phase_next = r_phase + 2'd1;
            end
        end
    end

    assign step_o  = w_step;
    assign mode_o  = r_mode;
    assign phase_o = r_phase;
    assign brake_o = r_brake_q;

    ucsbece152a_tl_pwm #(
        .PWM_PERIOD (PWM_PERIOD)
    ) u_pwm (
        .clk    (clk),
        .rst    (rst),
        .duty_i (duty_i),
        .dim_o  (dim_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_ucsbece152a_tl_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ucsbece152a_tl_scheduler
//  Description : Self-checking bench for the tail-light scheduler: a
//                cycle-level reference model compared every cycle, plus
//                hand-computed directed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ucsbece152a_tl_scheduler;
    import ucsbece152a_tl_pkg::*;

    localparam int SD = 4;
    localparam int P  = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       left_i, right_i, hazard_i, brake_i;
    logic [4:0] duty_i;
    logic       step_o;
    mode_t      mode_o;
    logic [1:0] phase_o;
    logic       brake_o;
    logic       dim_o;

    int checks = 0;
    int errors = 0;
    int ecnt   = 0;

    ucsbece152a_tl_scheduler #(
        .STEP_DIV   (SD),
        .PWM_PERIOD (P)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .left_i   (left_i),
        .right_i  (right_i),
        .hazard_i (hazard_i),
        .brake_i  (brake_i),
        .duty_i   (duty_i),
        .step_o   (step_o),
        .mode_o   (mode_o),
        .phase_o  (phase_o),
        .brake_o  (brake_o),
        .dim_o    (dim_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Edges since the last reset edge
    always @(posedge clk) ecnt <= rst ? 0 : ecnt + 1;

    // ---------------- reference model ----------------
    // Sequence lengths: idle 1, turn sweep 4, hazard flash 2 (modes 0..3)
    function automatic int seq_len(input int md);
        if (md == 0) return 1;
        if (md == 3) return 2;
        return 4;
    endfunction

    int m_cyc = 0, m_mode = 0, m_phase = 0, m_duty = 0;
    bit m_l = 0, m_r = 0, m_h = 0, m_brake = 0, m_valid = 0;

    always @(posedge clk) begin
        int arb;
        if (rst) begin
            m_cyc = 0; m_mode = 0; m_phase = 0; m_duty = 0;
            m_l = 0; m_r = 0; m_h = 0; m_brake = 0;
        end else begin
            if (m_cyc % SD == SD - 1) begin
                arb = (m_h || (m_l && m_r)) ? 3 : m_l ? 1 : m_r ? 2 : 0;
                if (m_phase == seq_len(m_mode) - 1) begin
                    m_mode = arb; m_phase = 0;
                end else if (arb == 3 && m_mode != 3) begin
                    m_mode = 3; m_phase = 0;
                end else begin
                    m_phase = m_phase + 1;
                end
            end
            if (m_cyc % P == P - 1) m_duty = int'(duty_i);
            m_cyc++;
            m_l = left_i; m_r = right_i; m_h = hazard_i; m_brake = brake_i;
        end
        m_valid = 1;
    end

    // Compare every cycle once the model has seen a reset edge
    always @(negedge clk) begin
        if (m_valid) begin
            chk("step",  int'(step_o),  (m_cyc % SD == SD - 1) ? 1 : 0);
            chk("mode",  int'(mode_o),  m_mode);
            chk("phase", int'(phase_o), m_phase);
            chk("brake", int'(brake_o), int'(m_brake));
            chk("dim",   int'(dim_o),   ((m_cyc % P) < m_duty) ? 1 : 0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic goto(input int e);
        int guard = 0;
        while (ecnt != e && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (ecnt != e) chk("goto_timeout", ecnt, e);
    endtask

    task automatic window(output int dims, output int steps);
        dims = 0; steps = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            dims  += int'(dim_o);
            steps += int'(step_o);
        end
    endtask

    initial begin
        int d, s;
        rst = 1'b1; left_i = 0; right_i = 0; hazard_i = 0; brake_i = 0;
        duty_i = 5'd4;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; left_i = 1'b1;
        @(negedge clk);
        chk("rst_step",  int'(step_o),  0);
        chk("rst_mode",  int'(mode_o),  0);
        chk("rst_phase", int'(phase_o), 0);
        chk("rst_brake", int'(brake_o), 0);
        chk("rst_dim",   int'(dim_o),   0);

        goto(3);  chk("first_step", int'(step_o), 1); chk("idle_before_step", int'(mode_o), 0);
        goto(4);  chk("left_mode", int'(mode_o), 1); chk("left_ph0", int'(phase_o), 0);
        goto(8);  chk("left_ph1", int'(phase_o), 1);
        hazard_i = 1'b1;
        goto(12); chk("preempt_mode", int'(mode_o), 3); chk("preempt_ph", int'(phase_o), 0);
        goto(16); chk("haz_ph1", int'(phase_o), 1);
        hazard_i = 1'b0;
        goto(20); chk("relaunch_left", int'(mode_o), 1); chk("relaunch_ph", int'(phase_o), 0);
        goto(24); chk("left_ph1b", int'(phase_o), 1);
        left_i = 1'b0; right_i = 1'b1;
        goto(28); chk("switch_keeps_left", int'(mode_o), 1); chk("switch_ph2", int'(phase_o), 2);
        goto(32); chk("switch_ph3", int'(phase_o), 3);
        goto(36); chk("right_mode", int'(mode_o), 2); chk("right_ph0", int'(phase_o), 0);
        goto(40);
        hazard_i = 1'b1; right_i = 1'b0;
        goto(44); chk("haz_from_right", int'(mode_o), 3);
        goto(48); chk("haz_ph1b", int'(phase_o), 1);
        brake_i = 1'b1;
        goto(49); chk("brake_pipe", int'(brake_o), 1); chk("dim_pre_rst", int'(dim_o), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; duty_i = 5'd16;
        chk("rst2_mode",  int'(mode_o),  0);
        chk("rst2_phase", int'(phase_o), 0);
        chk("rst2_brake", int'(brake_o), 0);
        chk("rst2_dim",   int'(dim_o),   0);

        goto(3);  chk("rst2_step", int'(step_o), 1); chk("rst2_idle", int'(mode_o), 0);
        goto(4);  chk("rst2_haz", int'(mode_o), 3);
        goto(15); chk("duty_deferred", int'(dim_o), 0);
        goto(16); chk("duty_applied", int'(dim_o), 1);

        goto(32); window(d, s);
        chk("dim_full", d, 16); chk("step_rate", s, 4);
        duty_i = 5'd0;
        goto(80); window(d, s);
        chk("dim_zero", d, 0);
        goto(100); duty_i = 5'd4;
        goto(128); window(d, s);
        chk("dim_quarter", d, 4);
        duty_i = 5'd8;
        goto(150); chk("mid_change_old", int'(dim_o), 0);
        goto(166); chk("mid_change_new", int'(dim_o), 1);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ucsbece152a_tl_scheduler.md
UCSBECE152A_TL_SCHEDULER -- requirements
Module: ucsbece152a_tl_scheduler

Interface
REQ-001 SHALL have parameter STEP_DIV, default 4, clock cycles per animation step (>=2).
REQ-002 SHALL have parameter PWM_PERIOD, default 16, clock cycles per dimmer period (>=2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports left_i, right_i, hazard_i, brake_i  input  1 each  driver requests.
REQ-006 SHALL have port duty_i  input  $clog2(PWM_PERIOD)+1  dimmer duty in clock cycles per period.
REQ-007 SHALL have port step_o  output  1  one-cycle animation step pulse.
REQ-008 SHALL have port mode_o  output  mode_t  active sequence: IDLE, LEFT, RIGHT or HAZARD.
REQ-009 SHALL have port phase_o  output  2  position within the active sequence.
REQ-010 SHALL have port brake_o  output  1  registered brake request.
REQ-011 SHALL have port dim_o  output  1  PWM dimmer enable for the running lights.

Function
REQ-012 Step counter SHALL count 0..STEP_DIV-1 and wrap to 0; step_o SHALL be high exactly when count == STEP_DIV-1.
REQ-013 Request inputs SHALL be registered once (req_q); arbitration SHALL use req_q only, giving 1-cycle input latency.
REQ-014 Arbitrated request SHALL be: HAZARD if hazard_q, or if left_q and right_q are both set; else LEFT if left_q; else RIGHT if right_q; else IDLE.
REQ-015 mode_o/phase_o SHALL change only on the clock edge that ends a cycle with step_o high; otherwise hold.
REQ-016 At a step, sequence boundary SHALL be: mode IDLE; LEFT/RIGHT with phase 3; or HAZARD with phase 1.
REQ-017 At a step on a boundary: mode <= arbitrated request and phase <= 0.
REQ-018 At a step off a boundary: LEFT/RIGHT SHALL advance phase by 1; HAZARD SHALL advance phase 0->1.
REQ-019 Exception: at a step in LEFT/RIGHT off a boundary with arbitrated request HAZARD, mode <= HAZARD, phase <= 0 (preemption).
REQ-020 A LEFT/RIGHT request that drops, or switches to the other side, mid-sequence SHALL NOT abort; the sequence completes through phase 3.
REQ-021 In IDLE, phase_o SHALL be 0.
REQ-022 brake_o SHALL equal brake_i delayed one cycle, independent of step and mode.
REQ-023 PWM counter SHALL count 0..PWM_PERIOD-1 and wrap; duty_i SHALL be sampled into duty_q only on the edge where the count wraps to 0.
REQ-024 dim_o SHALL be registered and high in a cycle iff (PWM count < duty_q); duty_q >= PWM_PERIOD gives constant 1 and duty_q = 0 gives constant 0.

Reset
REQ-025 While rst is high at a clock edge, the step counter, PWM counter, duty_q and req_q SHALL clear to 0; mode SHALL clear to IDLE, phase to 0.
REQ-026 In the cycle after reset, step_o, brake_o and dim_o SHALL read 0 and mode_o SHALL read IDLE.
REQ-027 Reset asserted mid-sequence SHALL abandon the sequence with no completion; the first step after release SHALL occur STEP_DIV cycles after the last reset edge.

Structure
REQ-028 Package ucsbece152a_tl_pkg SHALL hold typedef enum mode_t {IDLE, LEFT, RIGHT, HAZARD} and the phase-limit constants TURN_LAST=3 and HAZ_LAST=1.
REQ-029 The PWM counter, duty_q register and dim_o SHALL be contained in sub-module ucsbece152a_tl_pwm; step, arbitration and sequencing SHALL live in the top module.

Verification (STEP_DIV=4, PWM_PERIOD=16)
REQ-030 Reset release -> step_o pulses every 4th cycle, first pulse 4 cycles after the last reset edge; mode_o=IDLE.
REQ-031 Hold left_i=1 -> mode_o=LEFT at first step, phase_o then 0,1,2,3,0,... advancing once per step.
REQ-032 LEFT active at phase 1, right_i replaces left_i -> phase_o reaches 2 and 3, then RIGHT begins at phase 0.
REQ-033 LEFT active at phase 1, hazard_i raised -> at next step mode_o=HAZARD, phase_o=0; then phase_o alternates 0,1.
REQ-034 duty_i=4 -> dim_o high 4 of every 16 cycles; duty_i=16 -> dim_o constantly 1; duty_i=0 -> dim_o constantly 0; duty change mid-period takes effect from the next period.
REQ-035 rst pulsed while in HAZARD phase 1 with brake_i=1 -> next cycle mode_o=IDLE, phase_o=0, brake_o=0, dim_o=0.
